read_sequencer: RTL

Display-side read controller for the 4-channel capture memories. It tracks frame, line and pixel position from display timing strobes and generates the per-pixel read_address, line_number and latched display mode that drive the channel read organizer. It owns read access to the capture RAMs only while the capture side asserts mem_ready, and it re-latches display settings at each frame boundary.

---
 rtl/read_sequencer_if.sv | 29 ++
 rtl/read_sequencer.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/read_sequencer_if.sv
// Display-timing and read-address bundle between the display timing source
// (master) and the read sequencer (slave).
interface read_sequencer_if;
  logic        mem_ready;
  logic        frame_start;
  logic        line_start;
  logic        pixel_valid;
  logic [1:0]  mode_req;
  logic [12:0] window_start;
  logic [1:0]  zoom_shift;
  logic [14:0] read_address;
  logic [9:0]  line_number;
  logic [1:0]  mode;
  logic        rd_valid;
  logic        mode_err;
  logic        busy;

  modport master (
    output mem_ready, frame_start, line_start, pixel_valid,
           mode_req, window_start, zoom_shift,
    input  read_address, line_number, mode, rd_valid, mode_err, busy
  );

  modport slave (
    input  mem_ready, frame_start, line_start, pixel_valid,
           mode_req, window_start, zoom_shift,
    output read_address, line_number, mode, rd_valid, mode_err, busy
  );
endinterface

// File: rtl/read_sequencer.sv
// Display-side read controller: tracks frame/line/pixel position and issues
// capture-RAM read addresses while the capture side grants the memories.
module read_sequencer #(
  parameter int H_ACTIVE   = 640,
  parameter int BAND_LINES = 193,
  parameter int REGION     = 8192
) (
  input  logic             clk,
  input  logic             rst_n,
  read_sequencer_if.slave  bus
);
  localparam int AW   = 15;
  localparam int RW   = $clog2(REGION);
  localparam int XW   = $clog2(H_ACTIVE + 1);
  localparam int LW   = 10;
  localparam int HALF = H_ACTIVE / 2;
  localparam int QTR  = H_ACTIVE / 4;

  typedef enum logic [1:0] {IDLE, ARMED, SCAN} state_t;

  state_t          state_q, state_d;
  logic [XW-1:0]   x_q, x_d;
  logic [LW-1:0]   line_q, line_d;
  logic [1:0]      mode_q, mode_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            rd_valid_q, rd_valid_d;
  logic            mode_err_q, mode_err_d;
  logic [12:0]     ws_q, ws_d;
  logic [1:0]      zs_q, zs_d;

  logic [AW-1:0]   x_ext, xr, step, addr_calc;
  logic [1:0]      seg;
  logic [RW-1:0]   off;
  logic            line_ok;
  logic            accept;

  // Split x into a segment index and an in-segment offset per display mode.
  always_comb begin
    x_ext = AW'(x_q);
    seg   = 2'd0;
    xr    = x_ext;
    case (mode_q)
      2'd1: if (x_ext >= AW'(HALF)) begin
        seg = 2'd1;
        xr  = x_ext - AW'(HALF);
      end
      2'd0: begin
        if (x_ext >= AW'(3 * QTR)) begin
          seg = 2'd3;
          xr  = x_ext - AW'(3 * QTR);
        end else if (x_ext >= AW'(2 * QTR)) begin
          seg = 2'd2;
          xr  = x_ext - AW'(2 * QTR);
        end else if (x_ext >= AW'(QTR)) begin
          seg = 2'd1;
          xr  = x_ext - AW'(QTR);
        end
      end
      default: ;
    endcase
    step = xr << zs_q;
    off  = RW'(AW'(ws_q) + step);
    if (mode_q == 2'd0 || mode_q == 2'd1) addr_calc = {seg, off};
    else                                  addr_calc = AW'(ws_q) + step;

    case (mode_q)
      2'd0:    line_ok = (line_q < LW'(BAND_LINES));
      2'd1:    line_ok = (line_q < LW'(2 * BAND_LINES));
      default: line_ok = 1'b1;
    endcase
  end

  // NOTE: every _d gets a default first so no path leaves a latch behind.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    line_d     = line_q;
    mode_d     = mode_q;
    addr_d     = addr_q;
    rd_valid_d = 1'b0;
    mode_err_d = 1'b0;
    ws_d       = ws_q;
    zs_d       = zs_q;
    accept     = 1'b0;

    if (!bus.mem_ready) begin
      state_d = IDLE;
    end else begin
      accept = bus.frame_start && (state_q != IDLE);
      case (state_q)
        IDLE:    state_d = ARMED;
        ARMED:   if (accept) state_d = SCAN;
        SCAN:    state_d = SCAN;
        default: state_d = IDLE;
      endcase

      if (state_q == SCAN && bus.pixel_valid && x_q < XW'(H_ACTIVE)) begin
        x_d = x_q + XW'(1);
        if (line_ok) begin
          rd_valid_d = 1'b1;
          addr_d     = addr_calc;
        end
      end

      // Frame start outranks a coincident line start.
      if (accept) begin
        ws_d   = bus.window_start;
        zs_d   = bus.zoom_shift;
        line_d = '0;
        x_d    = '0;
        if (bus.mode_req != 2'd3) mode_d = bus.mode_req;
        else                      mode_err_d = 1'b1;
      end else if (state_q == SCAN && bus.line_start) begin
        if (line_q != '1) line_d = line_q + LW'(1);
        x_d = '0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      x_q        <= '0;
      line_q     <= '0;
      mode_q     <= 2'd2;
      addr_q     <= '0;
      rd_valid_q <= 1'b0;
      mode_err_q <= 1'b0;
      ws_q       <= '0;
      zs_q       <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      line_q     <= line_d;
      mode_q     <= mode_d;
      addr_q     <= addr_d;
      rd_valid_q <= rd_valid_d;
      mode_err_q <= mode_err_d;
      ws_q       <= ws_d;
      zs_q       <= zs_d;
    end
  end

  assign bus.read_address = addr_q;
  assign bus.line_number  = line_q;
  assign bus.mode         = mode_q;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.mode_err     = mode_err_q;
  assign bus.busy         = (state_q == SCAN);
endmodule
